// File: rtl/serial_addsub_if.sv
// rtl/serial_addsub_if.sv - start/busy/done operand and result bundle for serial_addsub
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;

  modport master (
    output start, mode, a, b, cin,
    input  busy, done, result, cout, ovf
  );

  modport slave (
    input  start, mode, a, b, cin,
    output busy, done, result, cout, ovf
  );
endinterface

// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - digit-serial two's-complement adder/subtractor, LSB first
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic           clk,
  input logic           rst_n,
  serial_addsub_if.slave bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [CW-1:0]    cnt;
  logic             chain;
  logic             mode_r;
  logic             a_msb;
  logic             b_msb;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] result_r;
  logic             cout_r;
  logic             ovf_r;

  logic [DIGIT-1:0] dbits;
  logic             chain_next;
  logic [WIDTH-1:0] res_next;

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.result = result_r;
  assign bus.cout   = cout_r;
  assign bus.ovf    = ovf_r;

  // Ripple the carry/borrow through the DIGIT low bits of the operand shifters.
  always_comb begin
    chain_next = chain;
    dbits      = '0;
    for (int i = 0; i < DIGIT; i++) begin
      dbits[i] = a_sh[i] ^ b_sh[i] ^ chain_next;
      if (mode_r)
        chain_next = (~a_sh[i] & b_sh[i]) | (~(a_sh[i] ^ b_sh[i]) & chain_next);
      else
        chain_next = (a_sh[i] & b_sh[i]) | (a_sh[i] & chain_next) | (b_sh[i] & chain_next);
    end
    res_next = (res_sh >> DIGIT) | (WIDTH'(dbits) << (WIDTH - DIGIT));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      cnt      <= '0;
      chain    <= 1'b0;
      mode_r   <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= '0;
      cout_r   <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            res_sh <= '0;
            chain  <= bus.cin;
            mode_r <= bus.mode;
            a_msb  <= bus.a[WIDTH-1];
            b_msb  <= bus.b[WIDTH-1];
            cnt    <= '0;
            busy_r <= 1'b1;
            state  <= RUN;
          end else begin
            busy_r <= 1'b0;
            state  <= IDLE;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> DIGIT;
          b_sh   <= b_sh >> DIGIT;
          res_sh <= res_next;
          chain  <= chain_next;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            // Overflow: operand signs match (add) or differ (sub) and result sign flips.
            result_r <= res_next;
            cout_r   <= chain_next;
            ovf_r    <= ((a_msb ^ b_msb) == mode_r) && (res_next[WIDTH-1] != a_msb);
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            state    <= DONE;
          end
        end
        default: begin
          busy_r <= 1'b0;
          done_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_addsub.sv
// tb/tb_serial_addsub.sv - self-checking bench for serial_addsub (8x1 and 16x4 instances)
module tb_serial_addsub;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_addsub_if #(.WIDTH(8))  if8 ();
  serial_addsub_if #(.WIDTH(16)) if16 ();

  serial_addsub #(.WIDTH(8),  .DIGIT(1)) dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
  serial_addsub #(.WIDTH(16), .DIGIT(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       m;
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] r;
    logic       co;
    logic       ov;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic void ref_model(input int w, input logic [15:0] a, input logic [15:0] b,
                                    input logic m, input logic c,
                                    output logic [15:0] r, output logic co, output logic ov);
    longint md, ua, ub, lc, sa, sb, full, sf;
    md = longint'(1) << w;
    ua = longint'(a);
    ub = longint'(b);
    lc = c ? 1 : 0;
    sa = (ua >= md / 2) ? ua - md : ua;
    sb = (ub >= md / 2) ? ub - md : ub;
    if (!m) begin
      full = ua + ub + lc;
      sf   = sa + sb + lc;
      co   = (full >= md);
    end else begin
      full = ua - ub - lc;
      sf   = sa - sb - lc;
      co   = (full < 0);
    end
    r  = 16'(full & (md - 1));
    ov = (sf >= md / 2) || (sf < -(md / 2));
  endfunction

  task automatic run8(input logic m, input logic [7:0] a, input logic [7:0] b, input logic c,
                      output logic [7:0] r, output logic co, output logic ov,
                      output int nb, output bit got);
    @(negedge clk);
    if8.mode = m; if8.a = a; if8.b = b; if8.cin = c; if8.start = 1'b1;
    @(negedge clk);
    if8.start = 1'b0;
    nb = 0; got = 1'b0; r = 'x; co = 1'bx; ov = 1'bx;
    for (int t = 0; t < 40 && !got; t++) begin
      if (if8.done) begin
        got = 1'b1; r = if8.result; co = if8.cout; ov = if8.ovf;
      end else begin
        if (if8.busy) nb++;
        @(negedge clk);
      end
    end
  endtask

  task automatic run16(input logic m, input logic [15:0] a, input logic [15:0] b, input logic c,
                       output logic [15:0] r, output logic co, output logic ov,
                       output int nb, output bit got);
    @(negedge clk);
    if16.mode = m; if16.a = a; if16.b = b; if16.cin = c; if16.start = 1'b1;
    @(negedge clk);
    if16.start = 1'b0;
    nb = 0; got = 1'b0; r = 'x; co = 1'bx; ov = 1'bx;
    for (int t = 0; t < 40 && !got; t++) begin
      if (if16.done) begin
        got = 1'b1; r = if16.result; co = if16.cout; ov = if16.ovf;
      end else begin
        if (if16.busy) nb++;
        @(negedge clk);
      end
    end
  endtask

  initial begin
    vec_t        tbl[8];
    logic [15:0] r, er;
    logic        co, ov, eco, eov;
    int          nb, pulses;
    bit          got;
    logic [15:0] ra, rb;
    logic        rm, rc;

    tbl[0] = '{1'b1, 8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 8'h05, 8'h05, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};

    if8.start = 0;  if8.mode = 0;  if8.a = 0;  if8.b = 0;  if8.cin = 0;
    if16.start = 0; if16.mode = 0; if16.a = 0; if16.b = 0; if16.cin = 0;
    repeat (3) @(negedge clk);
    check("reset_outs8", {if8.busy, if8.done, if8.result, if8.cout, if8.ovf}, '0);
    check("reset_outs16", {if16.busy, if16.done, if16.result, if16.cout, if16.ovf}, '0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run8(tbl[i].m, tbl[i].a, tbl[i].b, tbl[i].c, r[7:0], co, ov, nb, got);
      check($sformatf("vec%0d_done_seen", i), 32'(got), 32'd1);
      check($sformatf("vec%0d_result", i), 32'(r[7:0]), 32'(tbl[i].r));
      check($sformatf("vec%0d_cout_ovf", i), {co, ov}, {tbl[i].co, tbl[i].ov});
      check($sformatf("vec%0d_busy_cycles", i), nb, 8);
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", i), 32'(if8.done), 32'd0);
    end

    // start pulse in the third busy cycle must be ignored
    @(negedge clk);
    if8.mode = 1; if8.a = 8'h35; if8.b = 8'h12; if8.cin = 0; if8.start = 1;
    @(negedge clk); if8.start = 0;
    @(negedge clk);
    @(negedge clk);
    if8.mode = 0; if8.a = 8'hAA; if8.b = 8'h11; if8.start = 1;
    @(negedge clk); if8.start = 0;
    pulses = 0; r = '0;
    for (int t = 0; t < 20; t++) begin
      if (if8.done) begin pulses++; r[7:0] = if8.result; end
      @(negedge clk);
    end
    check("ignore_start_pulses", pulses, 1);
    check("ignore_start_result", 32'(r[7:0]), 32'h23);

    // start held through DONE: back-to-back with no idle gap
    @(negedge clk);
    if8.mode = 0; if8.a = 8'h10; if8.b = 8'h20; if8.cin = 0; if8.start = 1;
    @(negedge clk);
    if8.mode = 1; if8.a = 8'h50; if8.b = 8'h08;
    got = 0;
    for (int t = 0; t < 40 && !got; t++) begin
      if (if8.done) got = 1;
      else @(negedge clk);
    end
    check("b2b_first_done", 32'(got), 32'd1);
    check("b2b_first_result", 32'(if8.result), 32'h30);
    check("b2b_busy_in_done", 32'(if8.busy), 32'd0);
    @(negedge clk);
    if8.start = 0;
    check("b2b_no_gap_busy", {if8.busy, if8.done}, 2'b10);
    nb = 1; got = 0;
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge clk);
      if (if8.done) got = 1;
      else if (if8.busy) nb++;
    end
    check("b2b_second_done", 32'(got), 32'd1);
    check("b2b_second_result", {if8.result, if8.cout, if8.ovf}, {8'h48, 2'b00});
    check("b2b_second_busy", nb, 8);

    // reset mid-run aborts silently and clears the result registers
    @(negedge clk);
    if8.mode = 1; if8.a = 8'h35; if8.b = 8'h12; if8.cin = 0; if8.start = 1;
    @(negedge clk); if8.start = 0;
    repeat (3) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    check("midrun_reset_outs", {if8.busy, if8.done, if8.result, if8.cout, if8.ovf}, '0);
    rst_n = 1;
    pulses = 0;
    for (int t = 0; t < 20; t++) begin
      if (if8.done) pulses++;
      @(negedge clk);
    end
    check("midrun_reset_no_done", pulses, 0);

    run16(1'b1, 16'h1234, 16'h0235, 1'b0, r, co, ov, nb, got);
    check("w16_done_seen", 32'(got), 32'd1);
    check("w16_result", {r, co, ov}, {16'h0FFF, 2'b00});
    check("w16_busy_cycles", nb, 4);

    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rm = 1'($urandom); rc = 1'($urandom);
      ref_model(16, ra, rb, rm, rc, er, eco, eov);
      run16(rm, ra, rb, rc, r, co, ov, nb, got);
      check($sformatf("rand16_%0d m=%0d a=%h b=%h c=%0d", i, rm, ra, rb, rc),
            {got, r, co, ov, 8'(nb)}, {1'b1, er, eco, eov, 8'd4});
    end

    for (int i = 0; i < 200; i++) begin
      ra = {8'h00, 8'($urandom)}; rb = {8'h00, 8'($urandom)};
      rm = 1'($urandom); rc = 1'($urandom);
      ref_model(8, ra, rb, rm, rc, er, eco, eov);
      run8(rm, ra[7:0], rb[7:0], rc, r[7:0], co, ov, nb, got);
      check($sformatf("rand8_%0d m=%0d a=%h b=%h c=%0d", i, rm, ra[7:0], rb[7:0], rc),
            {got, r[7:0], co, ov, 8'(nb)}, {1'b1, er[7:0], eco, eov, 8'd8});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parametrised, digit-serial two's-complement adder/subtractor with a start/busy/done handshake.
- Successor to the fixed 4-bit ripple-borrow subtractor. Adds:
  - selectable add/sub mode,
  - arbitrary operand width,
  - configurable bits-per-cycle,
  - a signed overflow flag.
- Used in the datapath labs wherever area matters more than latency.
- Processes DIGIT bits per clock, LSB first, and presents a registered result on completion.

Parameters:
- WIDTH, 8, operand/result width in bits; must be ≥ 2.
- DIGIT, 1, bits processed per clock; must divide WIDTH; latency N = WIDTH/DIGIT.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request pulse; sampled only in IDLE or DONE
- mode  input  1  0 = add (a+b+cin), 1 = subtract (a−b−cin, cin acts as borrow-in)
- a  input  WIDTH  minuend / addend, captured on accepted start
- b  input  WIDTH  subtrahend / addend, captured on accepted start
- cin  input  1  carry-in (add) or borrow-in (sub), captured on accepted start
- busy  output  1  high while a computation is in progress
- done  output  1  one-cycle pulse; result/cout/ovf valid from this cycle on
- result  output  WIDTH  registered difference/sum
- cout  output  1  carry-out (add) or borrow-out (sub, 1 when a < b+cin unsigned)
- ovf  output  1  signed overflow of the WIDTH-bit operation

Behaviour:

Reset:
- rst_n=0 at a rising edge forces state=IDLE, busy=0, done=0, result=0, cout=0, ovf=0, and clears internal operand/shift/digit-counter registers.
- Reset mid-RUN aborts the operation silently; no done is issued.

States:
- IDLE: busy=0, done=0. start=1 → latch a, b, cin, mode; counter=0; go to RUN.
- RUN: busy=1.
  - Each cycle processes digit[counter] with the carry/borrow chain in a 1-bit register between digits.
  - Difference bit: a^b^borrow. Borrow: (~a&b) | (~(a^b)&borrow).
  - Sum bit: a^b^carry. Carry: majority(a, b, carry).
  - After digit N−1 → DONE.
- DONE: lasts exactly one cycle. done=1, busy=0.
  - result, cout and ovf were loaded at the edge entering DONE.
  - start=1 here is accepted exactly as in IDLE (back-to-back operation, next busy cycle follows immediately); otherwise → IDLE.

Timing:
- Edge capturing start → busy=1 for N cycles → done=1 in cycle N+1.
- Total start-to-done latency: N+1 edges.

Result registers:
- result/cout/ovf update only on the edge entering DONE.
- They hold their value through IDLE and through the next RUN until the next completion.

Handshake rules:
- start while busy=1 is ignored: no re-latch, no queueing.
- a, b, cin and mode may change freely after acceptance.

Overflow:
- add: ovf = (a[MSB]==b[MSB]) && (result[MSB]!=a[MSB]).
- sub: ovf = (a[MSB]!=b[MSB]) && (result[MSB]!=a[MSB]).
- Evaluated on the latched operands.

Wrap-around:
- Result is modulo 2^WIDTH.
- cout/borrow is the chain bit out of the MSB.

Simultaneous events:
- rst_n=0 dominates start.
- start in DONE takes effect while done=1 is still asserted that cycle.

Test Plan:
1. WIDTH=8, DIGIT=1, mode=1, a=0x35, b=0x12, cin=0, single-cycle start → busy high exactly 8 cycles, done pulse in cycle 9, result=0x23, cout=0, ovf=0.
2. mode=1, a=0x00, b=0x01, cin=0 → result=0xFF, cout=1, ovf=0. Then a=0x80, b=0x01 → result=0x7F, cout=0, ovf=1. Then a=0x05, b=0x05, cin=1 → result=0xFF, cout=1.
3. mode=0, a=0x7F, b=0x01, cin=0 → result=0x80, cout=0, ovf=1. Then a=0xFF, b=0x01, cin=0 → result=0x00, cout=1, ovf=0.
4. Pulse start again in the 3rd busy cycle with different operands → ignored; original result delivered; done fires once. Start held high during DONE → second operation begins with no idle gap; busy stays 0 only during the done cycle.
5. Drive rst_n=0 at busy cycle 4 of 8 → next cycle busy=0, done=0, result=0, cout=0, ovf=0, and no done pulse appears for 20 cycles.
6. WIDTH=16, DIGIT=4: mode=1, a=0x1234, b=0x0235, cin=0 → busy for exactly 4 cycles, result=0x0FFF, cout=0, ovf=0. Randomised 1000-vector check against a behavioural a±b±cin model.
